// File: rtl/timer_unit.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and
// level interrupt; 32-byte register window on the CPU data bus.
module timer_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        intimer
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_COUNT  = 3'd1;
    localparam logic [2:0] R_LOAD   = 3'd2;
    localparam logic [2:0] R_STATUS = 3'd3;
    localparam logic [2:0] R_PSC    = 3'd4;

    state_e      state_q, state_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        exp_q, exp_d;
    logic [31:0] count_q, count_d;
    logic [31:0] load_q, load_d;
    logic [15:0] psc_q, psc_d;
    logic [15:0] pre_q, pre_d;

    logic        hit;
    logic [2:0]  sel;
    logic        wr_en;
    logic        wr_ctrl, wr_count, wr_load, wr_status, wr_psc;
    logic        tick;
    logic        expire;
    logic        unused_addr;

    // Byte lanes are irrelevant: every register is a full word.
    assign unused_addr = ^addr[1:0];

    assign hit       = ce && (addr[31:5] == BASE_ADDR[31:5]);
    assign sel       = addr[4:2];
    assign wr_en     = hit && we;
    assign wr_ctrl   = wr_en && (sel == R_CTRL);
    assign wr_count  = wr_en && (sel == R_COUNT);
    assign wr_load   = wr_en && (sel == R_LOAD);
    assign wr_status = wr_en && (sel == R_STATUS);
    assign wr_psc    = wr_en && (sel == R_PSC);

    // Prescaler terminal count only matters while running.
    assign tick   = (state_q == RUN) && (pre_q == psc_q);
    assign expire = tick && (count_q == 32'd0);

    // Interrupt depends on flops only, never on the bus.
    assign intimer = exp_q & ie_q;

    // Next-state: counting first, then bus writes override it.
    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        exp_d   = exp_q;
        count_d = count_q;
        load_d  = load_q;
        psc_d   = psc_q;
        pre_d   = pre_q;

        if (state_q == RUN) begin
            pre_d = tick ? 16'd0 : 16'(pre_q + 16'd1);
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                state_d = IDLE;
            end
        end

        if (wr_status && wtData[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end

        unique case (1'b1)
            wr_ctrl: begin
                auto_d = wtData[1];
                ie_d   = wtData[2];
                if (wtData[0]) begin
                    state_d = RUN;
                    count_d = load_q;
                    pre_d   = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            wr_count: count_d = wtData;
            wr_load:  load_d  = wtData;
            wr_psc:   psc_d   = wtData[15:0];
            default: ;
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            count_q <= 32'd0;
            load_q  <= 32'd0;
            psc_q   <= 16'd0;
            pre_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            exp_q   <= exp_d;
            count_q <= count_d;
            load_q  <= load_d;
            psc_q   <= psc_d;
            pre_q   <= pre_d;
        end
    end

    // Read mux: zero unless this is a read hit on a mapped register.
    always_comb begin
        rdData = 32'h0;
        if (hit && !we) begin
            unique case (sel)
                R_CTRL:   rdData = {29'd0, ie_q, auto_q, state_q == RUN};
                R_COUNT:  rdData = count_q;
                R_LOAD:   rdData = load_q;
                R_STATUS: rdData = {31'd0, exp_q};
                R_PSC:    rdData = {16'd0, psc_q};
                default:  rdData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_unit.sv
// Directed testbench for timer_unit: register map, counting,
// expiry, write priority, decode and asynchronous reset.
module tb_timer_unit;

    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_COUNT  = BASE + 32'h04;
    localparam logic [31:0] A_LOAD   = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_PSC    = BASE + 32'h10;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        intimer;

    int errors = 0;
    int checks = 0;

    timer_unit #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .wtData (wtData),
        .rdData (rdData),
        .intimer(intimer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; wtData = d;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdData;
        ce = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                $display("FAIL reset_reg%0d: got %h expected 0", i, d);
                errors++;
            end
        end
        checks++;
        if (intimer !== 1'b0) begin
            $display("FAIL reset_intimer: got %b expected 0", intimer);
            errors++;
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'd0);
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd7);
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL auto_count0: got %0d expected 3", d);
            errors++;
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            rd(A_COUNT, d);
            checks++;
            if (d !== 32'(3 - k)) begin
                $display("FAIL auto_count%0d: got %0d expected %0d", k, d, 3 - k);
                errors++;
            end
            rd(A_STATUS, d);
            checks++;
            if (d !== 32'd0) begin
                $display("FAIL auto_exp_early%0d: got %0d expected 0", k, d);
                errors++;
            end
        end
        step();
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            $display("FAIL auto_exp: got %0d expected 1", d);
            errors++;
        end
        checks++;
        if (intimer !== 1'b1) begin
            $display("FAIL auto_intimer: got %b expected 1", intimer);
            errors++;
        end
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL auto_reload: got %0d expected 3", d);
            errors++;
        end
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL auto_w1c: got %0d expected 0", d);
            errors++;
        end
        step();
        step();
        step();
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            $display("FAIL auto_exp2: got %0d expected 1", d);
            errors++;
        end
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL auto_reload2: got %0d expected 3", d);
            errors++;
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        do_reset();
        wr(A_LOAD, 32'd2);
        wr(A_PSC, 32'd1);
        wr(A_CTRL, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            rd(A_STATUS, d);
            checks++;
            if (d !== 32'd0) begin
                $display("FAIL oneshot_early%0d: got %0d expected 0", k, d);
                errors++;
            end
        end
        step();
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            $display("FAIL oneshot_exp: got %0d expected 1", d);
            errors++;
        end
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL oneshot_ctrl: got %h expected 0", d);
            errors++;
        end
        checks++;
        if (intimer !== 1'b0) begin
            $display("FAIL oneshot_intimer: got %b expected 0", intimer);
            errors++;
        end
        repeat (3) step();
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL oneshot_hold: got %0d expected 0", d);
            errors++;
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'd0);
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd7);
        repeat (4) step();
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            $display("FAIL race_exp1: got %0d expected 1", d);
            errors++;
        end
        repeat (3) step();
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            $display("FAIL race_set_wins: got %0d expected 1", d);
            errors++;
        end
        checks++;
        if (intimer !== 1'b1) begin
            $display("FAIL race_intimer1: got %b expected 1", intimer);
            errors++;
        end
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL race_clear: got %0d expected 0", d);
            errors++;
        end
        checks++;
        if (intimer !== 1'b0) begin
            $display("FAIL race_intimer0: got %b expected 0", intimer);
            errors++;
        end
    endtask

    task automatic test_count_write();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'd0);
        wr(A_LOAD, 32'd5);
        wr(A_CTRL, 32'd1);
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd5) begin
            $display("FAIL cw_start: got %0d expected 5", d);
            errors++;
        end
        wr(A_COUNT, 32'd100);
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd100) begin
            $display("FAIL cw_write_wins: got %0d expected 100", d);
            errors++;
        end
        step();
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd99) begin
            $display("FAIL cw_next: got %0d expected 99", d);
            errors++;
        end
    endtask

    task automatic test_load_restart();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'd0);
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd3);
        wr(A_LOAD, 32'd9);
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd2) begin
            $display("FAIL lr_no_effect: got %0d expected 2", d);
            errors++;
        end
        repeat (3) step();
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd9) begin
            $display("FAIL lr_reload_new: got %0d expected 9", d);
            errors++;
        end
        checks++;
        if (intimer !== 1'b0) begin
            $display("FAIL lr_ie_off: got %b expected 0", intimer);
            errors++;
        end
        wr(A_CTRL, 32'd3);
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd9) begin
            $display("FAIL lr_restart: got %0d expected 9", d);
            errors++;
        end
        step();
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd8) begin
            $display("FAIL lr_after: got %0d expected 8", d);
            errors++;
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        do_reset();
        wr(A_LOAD, 32'h1234_5678);
        wr(BASE + 32'h14, 32'hFFFF_FFFF);
        wr(BASE + 32'h20, 32'hFFFF_FFFF);
        rd(BASE + 32'h14, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL dec_rd14: got %h expected 0", d);
            errors++;
        end
        rd(BASE + 32'h20, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL dec_rd20: got %h expected 0", d);
            errors++;
        end
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL dec_ctrl: got %h expected 0", d);
            errors++;
        end
        rd(A_PSC, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL dec_psc: got %h expected 0", d);
            errors++;
        end
        rd(BASE + 32'h0B, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            $display("FAIL dec_load_lanes: got %h expected 12345678", d);
            errors++;
        end
        ce = 1'b0; we = 1'b0; addr = A_LOAD;
        #1;
        checks++;
        if (rdData !== 32'h0) begin
            $display("FAIL dec_ce0: got %h expected 0", rdData);
            errors++;
        end
        wr(A_PSC, 32'hFFFF_1234);
        rd(A_PSC, d);
        checks++;
        if (d !== 32'h0000_1234) begin
            $display("FAIL dec_psc_mask: got %h expected 00001234", d);
            errors++;
        end
        wr(A_CTRL, 32'hFFFF_FFF6);
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h0000_0006) begin
            $display("FAIL dec_ctrl_mask: got %h expected 00000006", d);
            errors++;
        end
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL dec_idle_count: got %h expected 0", d);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        wr(A_PSC, 32'd0);
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'd7);
        step();
        checks++;
        if (intimer !== 1'b1) begin
            $display("FAIL ar_pre_intimer: got %b expected 1", intimer);
            errors++;
        end
        wr(A_LOAD, 32'd20);
        wr(A_PSC, 32'd3);
        wr(A_COUNT, 32'd7);
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd7) begin
            $display("FAIL ar_pre_count: got %0d expected 7", d);
            errors++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (intimer !== 1'b0) begin
            $display("FAIL ar_intimer: got %b expected 0", intimer);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 32'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                $display("FAIL ar_reg%0d: got %h expected 0", i, d);
                errors++;
            end
        end
        rst = 1'b1;
        repeat (3) step();
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL ar_idle_ctrl: got %h expected 0", d);
            errors++;
        end
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL ar_idle_count: got %h expected 0", d);
            errors++;
        end
    endtask

    initial begin
        rst = 1'b0;
        ce = 1'b0;
        we = 1'b0;
        addr = 32'h0;
        wtData = 32'h0;
        #12;
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_w1c_race();
        test_count_write();
        test_load_restart();
        test_decode();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
